// File: rtl/neuron_sequencer.sv
// rtl/neuron_sequencer.sv - neuron datapath sequencer: clear, MAC loop, bias, activation per neuron
// Supports run-time input count, operand stalls, multi-neuron jobs and abort.
module neuron_sequencer #(
  parameter int MAX_INPUTS = 16,
  parameter int IDX_W      = 4,
  parameter int NEURONS    = 1,
  parameter int NEU_W      = 1,
  parameter int USE_BIAS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len_m1,
  input  logic             in_valid,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             in_reg_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             bias_en,
  output logic             act_en,
  output logic [IDX_W-1:0] idx,
  output logic [NEU_W-1:0] neuron
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_MAC, S_BIAS, S_ACT, S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      neuron <= '0;
      len_q  <= '0;
    end else if (abort && state != S_IDLE) begin
      state  <= S_IDLE;
      idx    <= '0;
      neuron <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q  <= len_m1;
            idx    <= '0;
            neuron <= '0;
            state  <= S_CLR;
          end
        end
        S_CLR:   state <= S_FETCH;
        S_FETCH: if (in_valid) state <= S_MAC;
        S_MAC: begin
          // the last step is detected before incrementing, so idx never wraps
          if (idx == len_q) begin
            state <= (USE_BIAS != 0) ? S_BIAS : S_ACT;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_BIAS:  state <= S_ACT;
        S_ACT: begin
          if (neuron == NEU_W'(NEURONS - 1)) begin
            state <= S_DONE;
          end else begin
            neuron <= neuron + 1'b1;
            idx    <= '0;
            state  <= S_CLR;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign acc_clr   = (state == S_CLR);
  assign acc_en    = (state == S_MAC);
  assign bias_en   = (state == S_BIAS);
  assign act_en    = (state == S_ACT);
  assign in_reg_en = (state == S_FETCH) && in_valid;

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb/tb_neuron_sequencer.sv - scoreboard bench for neuron_sequencer
// Two instances: one neuron with bias, two neurons without bias, driven in lockstep.
module tb_neuron_sequencer;

  localparam int K_CLR  = 0;
  localparam int K_ACC  = 1;
  localparam int K_BIAS = 2;
  localparam int K_ACT  = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int kind;
    int idx;
    int neu;
    int cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len_m1;
  logic       in_valid;
  logic       abort;

  logic [1:0] ready_w, busy_w, done_w, in_reg_en_w;
  logic [1:0] acc_clr_w, acc_en_w, bias_en_w, act_en_w;
  logic [3:0] idx_w [2];
  logic [0:0] neuron_w [2];

  ev_t exp_q [2][$];
  int  checks;
  int  errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int NN = (gi == 0) ? 1 : 2;
    localparam int UB = (gi == 0) ? 1 : 0;

    neuron_sequencer #(
      .MAX_INPUTS(16), .IDX_W(4), .NEURONS(NN), .NEU_W(1), .USE_BIAS(UB)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .len_m1(len_m1),
      .in_valid(in_valid), .abort(abort),
      .ready(ready_w[gi]), .busy(busy_w[gi]), .done(done_w[gi]),
      .in_reg_en(in_reg_en_w[gi]), .acc_clr(acc_clr_w[gi]), .acc_en(acc_en_w[gi]),
      .bias_en(bias_en_w[gi]), .act_en(act_en_w[gi]),
      .idx(idx_w[gi]), .neuron(neuron_w[gi])
    );

    // monitor: samples just after the falling edge, after stimulus has settled
    initial begin
      int  bcnt;
      int  np;
      int  k;
      bit  prev_busy;
      bit  prev_ire;
      ev_t e;
      bcnt = 0;
      prev_busy = 1'b0;
      prev_ire = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (busy_w[gi]) bcnt = prev_busy ? bcnt + 1 : 1;
        np = $countones({acc_clr_w[gi], acc_en_w[gi], bias_en_w[gi], act_en_w[gi], done_w[gi]});
        chk($sformatf("inst%0d onehot_pulses", gi), int'(np <= 1), 1);
        chk($sformatf("inst%0d ready_vs_busy", gi), int'(ready_w[gi]), int'(!busy_w[gi]));
        if (in_reg_en_w[gi]) chk($sformatf("inst%0d in_reg_en_without_valid", gi), int'(in_valid), 1);
        if (np == 1) begin
          k = acc_clr_w[gi] ? K_CLR : acc_en_w[gi] ? K_ACC : bias_en_w[gi] ? K_BIAS :
              act_en_w[gi] ? K_ACT : K_DONE;
          if (exp_q[gi].size() == 0) begin
            chk($sformatf("inst%0d unexpected_event kind", gi), k, -1);
          end else begin
            e = exp_q[gi].pop_front();
            chk($sformatf("inst%0d event_kind", gi), k, e.kind);
            if (e.kind == K_ACC) begin
              chk($sformatf("inst%0d acc_idx", gi), int'(idx_w[gi]), e.idx);
              chk($sformatf("inst%0d acc_after_fetch", gi), int'(prev_ire), 1);
            end
            if (e.neu >= 0) chk($sformatf("inst%0d neuron", gi), int'(neuron_w[gi]), e.neu);
            if (e.cyc >= 0) chk($sformatf("inst%0d done_cycle", gi), bcnt, e.cyc);
          end
        end
        prev_busy = busy_w[gi];
        prev_ire = in_reg_en_w[gi];
      end
    end
  end

  // reference model: event list of a job derived from the sequencing rules
  task automatic push_job(input int len, input int stalls);
    for (int i = 0; i < 2; i++) begin
      int nn;
      int ub;
      nn = (i == 0) ? 1 : 2;
      ub = (i == 0) ? 1 : 0;
      for (int n = 0; n < nn; n++) begin
        exp_q[i].push_back('{K_CLR, -1, n, -1});
        for (int s = 0; s <= len; s++) exp_q[i].push_back('{K_ACC, s, n, -1});
        if (ub != 0) exp_q[i].push_back('{K_BIAS, -1, n, -1});
        exp_q[i].push_back('{K_ACT, -1, n, -1});
      end
      exp_q[i].push_back('{K_DONE, -1, -1,
                           (stalls < 0) ? -1 : nn * (2 * (len + 1) + 2 + ub) + stalls + 1});
    end
  endtask

  task automatic push_partial(input int last_idx);
    for (int i = 0; i < 2; i++) begin
      exp_q[i].push_back('{K_CLR, -1, 0, -1});
      for (int s = 0; s <= last_idx; s++) exp_q[i].push_back('{K_ACC, s, 0, -1});
    end
  endtask

  task automatic pulse_start(input int len, input bit ab);
    start = 1'b1;
    abort = ab;
    len_m1 = 4'(len);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    len_m1 = 4'($urandom_range(0, 15));
    for (int i = 0; i < 2; i++) chk($sformatf("inst%0d start_accepted", i), int'(busy_w[i]), 1);
  endtask

  task automatic wait_idle(input bit rand_valid);
    int n;
    n = 0;
    while (!(ready_w[0] && ready_w[1]) && n < 3000) begin
      if (rand_valid) in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    chk("idle_timeout", int'(n < 3000), 1);
  endtask

  task automatic wait_mac(input int val);
    int n;
    n = 0;
    while (!(acc_en_w[0] && idx_w[0] == 4'(val)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mac_wait_timeout", int'(n < 200), 1);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s inst%0d ready", tag, i), int'(ready_w[i]), 1);
      chk($sformatf("%s inst%0d busy", tag, i), int'(busy_w[i]), 0);
      chk($sformatf("%s inst%0d pulses", tag, i),
          $countones({acc_clr_w[i], acc_en_w[i], bias_en_w[i], act_en_w[i], done_w[i], in_reg_en_w[i]}), 0);
      chk($sformatf("%s inst%0d idx", tag, i), int'(idx_w[i]), 0);
      chk($sformatf("%s inst%0d neuron", tag, i), int'(neuron_w[i]), 0);
    end
  endtask

  initial begin
    int len;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    len_m1 = '0;
    in_valid = 1'b1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    // single job, in_valid held high
    push_job(3, 0);
    pulse_start(3, 1'b0);
    wait_idle(1'b0);

    // three-cycle stall while idx=2 is fetched
    push_job(3, 3);
    pulse_start(3, 1'b0);
    wait_mac(1);
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stall inst%0d in_reg_en", i), int'(in_reg_en_w[i]), 0);
        chk($sformatf("stall inst%0d idx", i), int'(idx_w[i]), 2);
      end
    end
    in_valid = 1'b1;
    wait_idle(1'b0);

    // single input per neuron
    push_job(0, 0);
    pulse_start(0, 1'b0);
    wait_idle(1'b0);

    // full length, with an ignored start while busy, then back-to-back start
    push_job(15, 0);
    pulse_start(15, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    len_m1 = 4'($urandom_range(0, 15));
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);
    push_job(5, 0);
    pulse_start(5, 1'b0);
    wait_idle(1'b0);

    // abort in MAC with idx=1, then a normal job
    push_partial(1);
    pulse_start(4, 1'b0);
    wait_mac(1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort inst%0d ready", i), int'(ready_w[i]), 1);
      chk($sformatf("abort inst%0d idx", i), int'(idx_w[i]), 0);
      chk($sformatf("abort inst%0d neuron", i), int'(neuron_w[i]), 0);
    end
    push_job(2, 0);
    pulse_start(2, 1'b0);
    wait_idle(1'b0);

    // reset asserted during FETCH
    for (int i = 0; i < 2; i++) exp_q[i].push_back('{K_CLR, -1, 0, -1});
    pulse_start(6, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midjob_reset");
    @(negedge clk);
    rst = 1'b1;

    // start together with abort in IDLE launches a job
    push_job(1, 0);
    pulse_start(1, 1'b1);
    wait_idle(1'b0);

    // random lengths with random operand stalls
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 15);
      push_job(len, -1);
      pulse_start(len, 1'b0);
      wait_idle(1'b1);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("inst%0d leftover_events", i), exp_q[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

endmodule
